// File: rtl/ps_cnd_eval.sv
// ps_cnd_eval: condition-code evaluator for a program sequencer.
// Resolves a 5-bit condition against the arithmetic status flags or the
// loop-counter-expired flag, and owns the hardware loop-counter stack
// whose top feeds that flag.
module ps_cnd_eval #(
  parameter int NSTAT    = 8,
  parameter int LC_DEPTH = 4,
  parameter int LCW      = 16,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnd_en,
  input  logic [4:0]       op_cnd,
  input  logic [NSTAT-1:0] astat_in,
  input  logic             astat_we,
  input  logic             lc_push,
  input  logic [LCW-1:0]   lc_init,
  input  logic             lc_pop,
  input  logic             lc_dec,
  input  logic             lc_err_clr,
  output logic             cnd_stat,
  output logic             cnd_vld,
  output logic [LCW-1:0]   lc_top,
  output logic             lce,
  output logic             lc_full,
  output logic             lc_empty,
  output logic             lc_err
);

  // Depth counter must hold 0..LC_DEPTH; entry index only 0..LC_DEPTH-1.
  localparam int DW = $clog2(LC_DEPTH + 1);
  localparam int AW = (LC_DEPTH > 1) ? $clog2(LC_DEPTH) : 1;

  localparam logic [4:0] OP_FOREVER = 5'b11111;

  logic [NSTAT-1:0] astat_q;
  logic [LCW-1:0]   stk [LC_DEPTH];
  logic [DW-1:0]    depth;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;

  logic [7:0]       s_p0;
  logic             res_p0;
  logic             cnd_stat_p1;
  logic             vld_p1;
  logic             err_set;

  // Loop counts saturate at zero so a stray decrement never wraps to a huge count.
  function automatic logic [LCW-1:0] sat_dec(input logic [LCW-1:0] v);
    sat_dec = (v == '0) ? '0 : v - LCW'(1);
  endfunction

  // Condition-code table: flag layout AZ,AV,AN,AC,MS,MV,SV,SZ in bits 0..7.
  function automatic logic base_sel(input logic [3:0] code,
                                    input logic [7:0] s,
                                    input logic       lc_exp);
    case (code)
      4'b0000: base_sel = s[0];
      4'b0001: base_sel = s[2];
      4'b0010: base_sel = s[0] | s[2];
      4'b0011: base_sel = s[3];
      4'b0100: base_sel = s[1];
      4'b0101: base_sel = lc_exp;
      4'b1000: base_sel = s[5];
      4'b1001: base_sel = s[4];
      4'b1010: base_sel = s[6];
      4'b1011: base_sel = s[7];
      default: base_sel = 1'b0;
    endcase
  endfunction

  assign top_idx  = AW'(depth - DW'(1));
  assign push_idx = AW'(depth);
  assign lc_empty = (depth == '0);
  assign lc_full  = (depth == DW'(LC_DEPTH));
  assign lc_top   = lc_empty ? '0 : stk[top_idx];
  assign lce      = !lc_empty && (lc_top == LCW'(1));

  // Stage p0: pick status source (optionally forwarding a same-cycle write) and evaluate.
  always_comb begin
    s_p0 = 8'((BYPASS != 0 && astat_we) ? astat_in : astat_q);
    if (op_cnd == OP_FOREVER)
      res_p0 = 1'b1;
    else
      res_p0 = base_sel(op_cnd[3:0], s_p0, lce) ^ op_cnd[4];
  end

  // Stage p1: register the result; an idle cycle yields a zero result and no valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnd_stat_p1 <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      cnd_stat_p1 <= cnd_en & res_p0;
      vld_p1      <= cnd_en;
    end
  end

  assign cnd_stat = cnd_stat_p1;
  assign cnd_vld  = vld_p1;

  // Status register: holds until explicitly loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      astat_q <= '0;
    else if (astat_we)
      astat_q <= astat_in;
  end

  // Loop-counter stack; push beats pop beats dec, push+pop on a live top replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      for (int i = 0; i < LC_DEPTH; i++)
        stk[i] <= '0;
    end else begin
      if (lc_push && lc_pop && !lc_empty) begin
        stk[top_idx] <= lc_init;
      end else if (lc_push) begin
        if (!lc_full) begin
          stk[push_idx] <= lc_init;
          depth         <= depth + DW'(1);
        end
      end else if (lc_pop) begin
        if (!lc_empty)
          depth <= depth - DW'(1);
      end else if (lc_dec && !lc_empty) begin
        stk[top_idx] <= sat_dec(stk[top_idx]);
      end
    end
  end

  // Overflow (plain push when full) or underflow (plain pop when empty).
  assign err_set = (lc_push && !lc_pop && lc_full) ||
                   (lc_pop && !lc_push && lc_empty);

  // Sticky error flag; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lc_err <= 1'b0;
    else if (err_set)
      lc_err <= 1'b1;
    else if (lc_err_clr)
      lc_err <= 1'b0;
  end

endmodule

// File: doc/ps_cnd_eval.md
PS_CND_EVAL -- requirements
Module: ps_cnd_eval

Interface
REQ-001 SHALL have parameter NSTAT, default 8, giving the status width; bits 0..7 are AZ, AV, AN, AC, MS, MV, SV, SZ.
REQ-002 SHALL have parameter LC_DEPTH, default 4, giving the loop-counter stack depth (>=2).
REQ-003 SHALL have parameter LCW, default 16, giving the loop-counter width.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = forward astat_in on the cycle it is written.
REQ-005 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cnd_en  input  1  evaluate request.
REQ-008 SHALL have port op_cnd  input  5  condition code; bit4 inverts, 5'b11111 = FOREVER.
REQ-009 SHALL have port astat_in  input  NSTAT  new status value.
REQ-010 SHALL have port astat_we  input  1  status register load.
REQ-011 SHALL have port lc_push  input  1  push lc_init onto the stack.
REQ-012 SHALL have port lc_init  input  LCW  initial loop count.
REQ-013 SHALL have port lc_pop  input  1  pop the stack top.
REQ-014 SHALL have port lc_dec  input  1  decrement the stack top.
REQ-015 SHALL have port lc_err_clr  input  1  clear the sticky error.
REQ-016 SHALL have port cnd_stat  output  1  registered condition result.
REQ-017 SHALL have port cnd_vld  output  1  one-cycle pulse qualifying cnd_stat.
REQ-018 SHALL have port lc_top  output  LCW  current stack top, 0 when empty.
REQ-019 SHALL have port lce  output  1  loop counter expired: stack non-empty and lc_top==1.
REQ-020 SHALL have ports lc_full and lc_empty  output  1 each  stack occupancy flags.
REQ-021 SHALL have port lc_err  output  1  sticky overflow/underflow flag.

Function
REQ-022 SHALL sample cnd_en and op_cnd at a clock edge and present cnd_stat and cnd_vld on the following cycle (latency 1).
REQ-023 SHALL use the status register value as status source S; when BYPASS=1 and astat_we is high, S SHALL be astat_in.
REQ-024 SHALL compute base B from op_cnd[3:0]: 0000 S0; 0001 S2; 0010 S0|S2; 0011 S3; 0100 S1; 0101 lce; 1000 S5; 1001 S4; 1010 S6; 1011 S7; all other codes 0.
REQ-025 SHALL set the result to 1 for op_cnd=11111 and to B^op_cnd[4] otherwise.
REQ-026 SHALL register cnd_stat=0 and cnd_vld=0 when cnd_en is low.
REQ-027 SHALL evaluate lce from stack state before that edge's push/pop/dec.
REQ-028 SHALL hold the status register except on astat_we, which loads astat_in.
REQ-029 SHALL, on push while not full, write lc_init as the new top and increment depth.
REQ-030 SHALL, on pop while not empty, discard the top; the previous entry becomes the top.
REQ-031 SHALL, on dec while not empty, decrement the top, saturating at 0 without wrap.
REQ-032 SHALL, when push and pop coincide with the stack non-empty, replace the top with lc_init and leave depth unchanged; with the stack empty, SHALL act as push.
REQ-033 SHALL ignore dec when push or pop is also active (priority push > pop > dec).
REQ-034 SHALL ignore push when full (except under REQ-032) and pop when empty, setting lc_err in either case.
REQ-035 SHALL keep lc_err set until lc_err_clr; a new error in the same cycle as lc_err_clr SHALL win.
REQ-036 SHALL ignore dec on an empty stack without setting lc_err.

Reset
REQ-037 SHALL, on rst_n low, immediately clear cnd_stat, cnd_vld, lc_err, the status register, all stack entries and the depth, giving lc_empty=1, lc_full=0, lc_top=0, lce=0.
REQ-038 SHALL discard any evaluation pending when reset is asserted mid-operation; no cnd_vld SHALL follow reset release until a new cnd_en is sampled.

Verification
REQ-039 SHALL cover: astat_we with astat_in=8'h01 plus cnd_en with op_cnd=00000 in the same cycle (BYPASS=1) -> next cycle cnd_stat=1, cnd_vld=1; with op_cnd=10000 -> cnd_stat=0.
REQ-040 SHALL cover: push lc_init=3, then dec twice -> lce=1 when lc_top=1; cnd_en with op_cnd=00101 -> cnd_stat=1; op_cnd=10101 -> 0.
REQ-041 SHALL cover: four pushes plus a fifth (LC_DEPTH=4) -> lc_full=1, top unchanged, lc_err=1; lc_err_clr -> 0.
REQ-042 SHALL cover: empty stack, pop -> lc_err=1, lc_empty stays 1; simultaneous push and pop with lc_init=7 on an empty stack -> depth 1, lc_top=7.
REQ-043 SHALL cover: op_cnd=11111 with all status bits zero -> cnd_stat=1; cnd_en=0 -> cnd_stat=0 and cnd_vld=0; undefined code 00110 -> 0, 10110 -> 1.
REQ-044 SHALL cover: rst_n pulsed low between the cnd_en sample and the result cycle -> cnd_vld=0, stack empty, status register 0.
